// File: rtl/aurora_pkg.sv
// Shared types and defaults for the Aurora RX packet path.
package aurora_pkg;
    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_LOG2_DEF = 9;

    typedef enum logic {PASS = 1'b0, DROP = 1'b1} wr_state_e;

    // One extra bit over the RAM address separates full from empty.
    typedef logic [DEPTH_LOG2_DEF:0] ptr_t;
endpackage

// File: rtl/rx_pkt_buffer_if.sv
// AXI-Stream beat bundle used for both the RX input and the buffered output.
interface rx_pkt_buffer_if
    import aurora_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tready;

    modport master   (output tvalid, tdata, tlast, input tready);
    modport slave    (input tvalid, tdata, tlast, output tready);
    // The Aurora RX path has no backpressure, so its sink never sees tready.
    modport rx_slave (input tvalid, tdata, tlast);
endinterface

// File: rtl/rx_pkt_ram.sv
// Simple dual-port RAM with 1-cycle synchronous read; unreset so it maps to block RAM.
module rx_pkt_ram
    import aurora_pkg::*;
#(
    parameter int ADDR_W = DEPTH_LOG2_DEF,
    parameter int DATA_W = DATA_W_DEF + 1
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end
endmodule

// File: rtl/rx_pkt_buffer.sv
// Store-and-forward RX buffer: beats are held until their packet's tlast, packets
// that do not fit are dropped whole, committed data drains on a backpressured stream.
module rx_pkt_buffer
    import aurora_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    rx_pkt_buffer_if.rx_slave s_axis,
    rx_pkt_buffer_if.master   m_axis,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       drop_cnt,
    output logic              overflow
);
    typedef logic [DEPTH_LOG2:0] bptr_t;
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    localparam bptr_t DEPTH = bptr_t'(2 ** DEPTH_LOG2);

    wr_state_e   state_q;
    bptr_t       wr_ptr_q, wr_commit_q, rd_ptr_q, used;
    logic [31:0] pkt_cnt_q, drop_cnt_q;
    logic        overflow_q, full, wr_en;
    beat_t       wr_beat, rd_beat;
    logic        rd_en, inflight_q, pop;
    logic [1:0]  q_cnt_q, q_cnt_d, occ;
    beat_t       q0_q, q0_d, q1_q, q1_d;

    assign used    = wr_ptr_q - rd_ptr_q;
    assign full    = (used == DEPTH);
    assign wr_en   = s_axis.tvalid && (state_q == PASS) && !full;
    assign wr_beat = {s_axis.tlast, s_axis.tdata};

    rx_pkt_ram #(.ADDR_W(DEPTH_LOG2), .DATA_W(DATA_W + 1)) u_ram (
        .clk_i     (m_axis_aclk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i (wr_beat),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_beat)
    );

    // Full drops rewind to the last commit so the partial packet is never readable.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q     <= PASS;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (s_axis.tvalid) begin
                case (state_q)
                    PASS: begin
                        if (!full) begin
                            wr_ptr_q <= wr_ptr_q + bptr_t'(1);
                            if (s_axis.tlast) begin
                                wr_commit_q <= wr_ptr_q + bptr_t'(1);
                                pkt_cnt_q   <= pkt_cnt_q + 32'd1;
                            end
                        end else begin
                            wr_ptr_q   <= wr_commit_q;
                            overflow_q <= 1'b1;
                            if (s_axis.tlast) drop_cnt_q <= drop_cnt_q + 32'd1;
                            else              state_q    <= DROP;
                        end
                    end
                    DROP: begin
                        if (s_axis.tlast) begin
                            drop_cnt_q <= drop_cnt_q + 32'd1;
                            state_q    <= PASS;
                        end
                    end
                    default: state_q <= PASS;
                endcase
            end
        end
    end

    // Occupancy is taken net of this cycle's pop so reads keep pace at 1 beat/cycle.
    assign pop   = (q_cnt_q != 2'd0) && m_axis.tready;
    assign occ   = q_cnt_q - 2'(pop) + 2'(inflight_q);
    assign rd_en = (rd_ptr_q != wr_commit_q) && (occ < 2'd2);

    always_comb begin
        q0_d    = q0_q;
        q1_d    = q1_q;
        q_cnt_d = q_cnt_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (q_cnt_q == 2'd0) q0_d = rd_beat;
                else                 q1_d = rd_beat;
                q_cnt_d = q_cnt_q + 2'd1;
            end
            2'b01: begin
                q0_d    = q1_q;
                q_cnt_d = q_cnt_q - 2'd1;
            end
            2'b11: begin
                if (q_cnt_q == 2'd1) begin
                    q0_d = rd_beat;
                end else begin
                    q0_d = q1_q;
                    q1_d = rd_beat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            q_cnt_q    <= '0;
            q0_q       <= '0;
            q1_q       <= '0;
        end else begin
            if (rd_en) rd_ptr_q <= rd_ptr_q + bptr_t'(1);
            inflight_q <= rd_en;
            q_cnt_q    <= q_cnt_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
        end
    end

    assign m_axis.tvalid = (q_cnt_q != 2'd0);
    assign m_axis.tdata  = q0_q.data;
    assign m_axis.tlast  = q0_q.last;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_rx_pkt_buffer.sv
// Scoreboard bench for rx_pkt_buffer at DEPTH_LOG2=4 (16-word buffer).
module tb_rx_pkt_buffer;
    import aurora_pkg::*;

    localparam int DL = 4;
    localparam int DW = 32;
    typedef logic [DW:0] beat_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pkt_cnt, drop_cnt;
    logic        overflow;

    rx_pkt_buffer_if #(.DATA_W(DW)) s_if ();
    rx_pkt_buffer_if #(.DATA_W(DW)) m_if ();
    assign s_if.tready = 1'b1;

    rx_pkt_buffer #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .pkt_cnt        (pkt_cnt),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    beat_t obs[$];
    int    n_ovf, stall_viol;
    bit    tgl;
    bit    prev_stall;
    beat_t prev_beat;

    // Observer: records accepted beats, overflow pulses and stall-stability breaks.
    always @(negedge clk) begin
        if (!rst_n) begin
            obs.delete();
            n_ovf      = 0;
            stall_viol = 0;
            prev_stall = 1'b0;
        end else begin
            if (overflow) n_ovf++;
            if (prev_stall && (!m_if.tvalid || {m_if.tlast, m_if.tdata} !== prev_beat)) stall_viol++;
            if (m_if.tvalid && m_if.tready) obs.push_back({m_if.tlast, m_if.tdata});
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tlast, m_if.tdata};
        end
    end

    task automatic step();
        if (tgl) m_if.tready = ~m_if.tready;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input bit expect_out);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        if (expect_out) sb.push_back({l, d});
        step();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int c = 0; c < budget && obs.size() < n; c++) step();
        repeat (4) step();
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        tgl         = 1'b0;
        rst_n       = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %0b want 0", m_if.tvalid); end
        checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", m_if.tdata); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %0b want 0", m_if.tlast); end
        checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
        checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_single();
        int    hi, n;
        beat_t got, want;
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 1; i <= 5; i++) beat(32'(i), (i == 5), 1'b1);
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_lat0: tvalid %0b want 0", m_if.tvalid); end
        step();
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_lat1: tvalid %0b want 0", m_if.tvalid); end
        step();
        checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL single_lat2: tvalid %0b want 1", m_if.tvalid); end
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_if.tvalid === 1'b1) hi++;
            step();
        end
        checks++; if (hi != 5) begin errors++; $display("FAIL single_burst: %0d valid cycles want 5", hi); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_end: tvalid %0b want 0", m_if.tvalid); end
        n = sb.size();
        wait_out(n, 50);
        checks++; if (obs.size() != n) begin errors++; $display("FAIL single_count: got %0d beats want %0d", obs.size(), n); end
        for (int i = 0; i < n; i++) begin
            want = sb.pop_front();
            got  = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL single_beat%0d: got %h want %h", i, got, want); end
        end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        int    n;
        beat_t got, want;
        do_reset();
        tgl = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) beat(32'h100 + 32'(p * 4 + i), (i == 3), 1'b1);
        n = sb.size();
        wait_out(n, 100);
        checks++; if (obs.size() != n) begin errors++; $display("FAIL bp_count: got %0d beats want %0d", obs.size(), n); end
        for (int i = 0; i < n; i++) begin
            want = sb.pop_front();
            got  = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got, want); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_viol); end
        checks++; if (pkt_cnt !== 32'd3) begin errors++; $display("FAIL bp_pkt_cnt: got %0d want 3", pkt_cnt); end
        checks++; if (n_ovf != 0) begin errors++; $display("FAIL bp_ovf: got %0d pulses want 0", n_ovf); end
    endtask

    // With tready low the output queue still prefetches two words of A, freeing
    // two RAM slots, so the 16-word RAM fills on the 9th word of B.
    task automatic test_overflow();
        int    n;
        beat_t got, want;
        do_reset();
        for (int i = 0; i < 10; i++) beat(32'h200 + 32'(i), (i == 9), 1'b1);
        for (int i = 1; i <= 10; i++) begin
            beat(32'h300 + 32'(i), (i == 10), 1'b0);
            if (i == 8) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b want 0", overflow); end
            end
            if (i == 9) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b want 1", overflow); end
            end
        end
        step();
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", n_ovf); end
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL ovf_pkt_cnt: got %0d want 1", pkt_cnt); end
        m_if.tready = 1'b1;
        n = sb.size();
        wait_out(n, 60);
        checks++; if (obs.size() != n) begin errors++; $display("FAIL ovf_count: got %0d beats want %0d", obs.size(), n); end
        for (int i = 0; i < n; i++) begin
            want = sb.pop_front();
            got  = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, got, want); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL ovf_stable: %0d unstable stalls want 0", stall_viol); end
    endtask

    task automatic test_oversize();
        int    n;
        beat_t got, want;
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 0; i < 20; i++) beat(32'h400 + 32'(i), (i == 19), 1'b0);
        repeat (4) step();
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL big_leak: got %0d beats want 0", obs.size()); end
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL big_drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL big_ovf: got %0d pulses want 1", n_ovf); end
        for (int i = 0; i < 3; i++) beat(32'h500 + 32'(i), (i == 2), 1'b1);
        n = sb.size();
        wait_out(n, 40);
        checks++; if (obs.size() != n) begin errors++; $display("FAIL big_count: got %0d beats want %0d", obs.size(), n); end
        for (int i = 0; i < n; i++) begin
            want = sb.pop_front();
            got  = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL big_beat%0d: got %h want %h", i, got, want); end
        end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL big_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_full_on_tlast();
        int    n;
        beat_t got, want;
        do_reset();
        for (int i = 0; i < 10; i++) beat(32'h600 + 32'(i), (i == 9), 1'b1);
        for (int i = 0; i < 9; i++) beat(32'h700 + 32'(i), (i == 8), 1'b0);
        step();
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL ftl_drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL ftl_ovf: got %0d pulses want 1", n_ovf); end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL ftl_pkt_cnt: got %0d want 1", pkt_cnt); end
        m_if.tready = 1'b1;
        wait_out(10, 60);
        for (int i = 0; i < 2; i++) beat(32'h800 + 32'(i), (i == 1), 1'b1);
        n = sb.size();
        wait_out(n, 40);
        checks++; if (obs.size() != n) begin errors++; $display("FAIL ftl_count: got %0d beats want %0d", obs.size(), n); end
        for (int i = 0; i < n; i++) begin
            want = sb.pop_front();
            got  = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL ftl_beat%0d: got %h want %h", i, got, want); end
        end
        checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL ftl_pkt_cnt2: got %0d want 2", pkt_cnt); end
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL ftl_drop_cnt2: got %0d want 1", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        int    n;
        beat_t got, want;
        do_reset();
        for (int i = 0; i < 2; i++) beat(32'h900 + 32'(i), (i == 1), 1'b0);
        for (int i = 0; i < 3; i++) beat(32'hA00 + 32'(i), 1'b0, 1'b0);
        checks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h900) begin
            errors++; $display("FAIL mid_pre: tvalid %0b tdata %h want 1 00000900", m_if.tvalid, m_if.tdata); end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 1", pkt_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %0b want 0", m_if.tvalid); end
        checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL mid_tdata: got %h want 0", m_if.tdata); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL mid_tlast: got %0b want 0", m_if.tlast); end
        checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL mid_pkt_cnt: got %0d want 0", pkt_cnt); end
        checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %0b want 0", overflow); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        for (int i = 0; i < 2; i++) beat(32'hB00 + 32'(i), (i == 1), 1'b1);
        n = sb.size();
        wait_out(n, 30);
        checks++; if (obs.size() != n) begin errors++; $display("FAIL mid_count: got %0d beats want %0d", obs.size(), n); end
        for (int i = 0; i < n; i++) begin
            want = sb.pop_front();
            got  = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL mid_beat%0d: got %h want %h", i, got, want); end
        end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL mid_pkt_cnt2: got %0d want 1", pkt_cnt); end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        tgl         = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_oversize();
        test_full_on_tlast();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
